// File: rtl/instr_fetch.sv
// Program store and loader feeding the datapath: 256 x 8 memory filled from a load port, fetched on CLK_ rises.
// Optional INSTR_FETCH_BOOT_PROGRAM_EN preloads a 6-byte boot program on every RESET.
module instr_fetch #(
  parameter logic [7:0] FILL = 8'h00
) (
  input  logic       _CLK,
  input  logic       RESET,
  input  logic [7:0] load_data,
  input  logic       load_strobe,
  input  logic       load_done,
  input  logic       run,
  input  logic [7:0] PC,
  input  logic       CLK_,
  output logic [7:0] instruction,
  output logic [1:0] state,
  output logic [8:0] prog_len,
  output logic       full,
  output logic       hold_reset
);

  // state | meaning
  // IDLE  | datapath held in reset, waiting for a load or run
  // LOAD  | accepting program bytes at wp
  // RUN   | datapath released, fetching on CLK_ rises
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10} state_t;

  state_t     state_q, state_d;
  logic [7:0] mem [0:255];
  logic [7:0] wp;
  logic [7:0] wr_addr;
  logic       wr_en;
  logic       c1;
  logic       rise;
  logic       run_entry;

  assign rise       = CLK_ & ~c1;
  assign full       = (prog_len == 9'd256);
  assign hold_reset = (state_q != RUN);
  assign state      = state_q;
  assign run_entry  = (state_q != RUN) && (state_d == RUN);

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_addr = wp;
    case (state_q)
      IDLE: begin
        if (load_strobe) begin
          wr_en   = 1'b1;
          wr_addr = 8'd0;
          state_d = LOAD;
        end else if (run) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (load_strobe && !full) wr_en = 1'b1;
        if (load_done) state_d = IDLE;
      end
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge _CLK) begin
    c1 <= CLK_;
    if (RESET) begin
      state_q     <= IDLE;
      wp          <= 8'd0;
      instruction <= 8'h00;
`ifdef INSTR_FETCH_BOOT_PROGRAM_EN
      prog_len    <= 9'd6;
`else
      prog_len    <= 9'd0;
`endif
    end else begin
      state_q <= state_d;
      if (wr_en) begin
        // wp may wrap to 0 after byte 256; full blocks any further write
        wp       <= wr_addr + 8'd1;
        prog_len <= {1'b0, wr_addr} + 9'd1;
      end
      if (run_entry)
        instruction <= (prog_len == 9'd0) ? FILL : mem[0];
      else if (state_q == RUN && rise)
        instruction <= ({1'b0, PC} < prog_len) ? mem[PC] : FILL;
    end
  end

  // Contents survive reset; prog_len masks anything stale
  always_ff @(posedge _CLK) begin
`ifdef INSTR_FETCH_BOOT_PROGRAM_EN
    if (RESET) begin
      mem[0] <= 8'h73;
      mem[1] <= 8'h4D;
      mem[2] <= 8'h74;
      mem[3] <= 8'hB7;
      mem[4] <= 8'h05;
      mem[5] <= 8'hC2;
    end else if (wr_en) begin
      mem[wr_addr] <= load_data;
    end
`else
    if (!RESET && wr_en) mem[wr_addr] <= load_data;
`endif
  end

endmodule
